hrm_memory_ext: RTL and testbench
=================================

Name: hrm_memory_ext

Overview:
- Parametrised successor to the HRM floor-tile memory: synchronous-read RAM with an address register (AR), loaded directly from ADDR or indirectly from the current tile value M.
- Adds generic width and depth, HRM BUMP+/BUMP- as an internal read-modify-write sequence, and a clear sequencer that zeroes all tiles, optionally at reset release.
- Sits between the control unit and the datapath (R register in, M out to the ALU and mux).

Parameters:
- DATA_W, 8, tile data width (two's complement).
- ADDR_W, 5, AR/ADDR width.
- DEPTH, 32, number of tiles; must satisfy DEPTH <= 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = run the clear sequence automatically after reset release.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ADDR  in  ADDR_W  direct address operand.
- R  in  DATA_W  write data (accumulator register).
- srcA  in  1  AR source: 0 = ADDR, 1 = M[ADDR_W-1:0] (indirect).
- wAR  in  1  load AR.
- wM  in  1  write R to mem[AR].
- bump_inc  in  1  start BUMP+ on mem[AR].
- bump_dec  in  1  start BUMP- on mem[AR].
- clr_start  in  1  start the clear sequence.
- M  out  DATA_W  registered tile value at AR.
- AR  out  ADDR_W  current address register.
- busy  out  1  a sequence is running; commands are ignored.
- bump_done  out  1  one-cycle pulse when a bump completes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - AR=0, M=0, busy=0, bump_done=0, clear counter=0.
  - State = CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - RAM contents are not reset.
  - busy is high combinationally whenever the state is not IDLE, including during reset when entering CLEAR.
- States: IDLE, CLEAR, BUMP_RD, BUMP_WR.
- M register, every edge:
  - M <= wdata if a write targets AR this edge (write-first); otherwise M <= mem[AR].
  - Read latency is 1 cycle after AR or memory changes.
- IDLE command priority: clr_start > bump > wAR/wM.
  - bump_inc and bump_dec both high: ignored, no pulse.
- wAR and wM together: the write uses the old AR; AR loads at the same edge.
- Indirect load (srcA=1) uses the low ADDR_W bits of M as registered at that edge.
- Out-of-range addresses (AR >= DEPTH): writes and bumps are dropped (bump still pulses bump_done); M reads 0.
- Bump sequence:
  - Edge k: accept, go to BUMP_RD, op latched.
  - Edge k+1: go to BUMP_WR; M = mem[AR].
  - Edge k+2: mem[AR] <= M±1, M <= M±1, go to IDLE, bump_done=1 for one cycle.
  - Arithmetic wraps modulo 2**DATA_W.
  - Total busy time is 2 cycles.
- Clear sequence:
  - Edge k: accept, counter=0.
  - Each edge in CLEAR writes 0 to mem[counter] and increments the counter.
  - On the edge that writes DEPTH-1, go to IDLE; M <= 0.
  - busy is high for exactly DEPTH cycles; AR is unchanged.
- Commands while busy (wAR, wM, bump, clr): ignored entirely; AR holds.
- Reset mid-sequence aborts immediately; partially cleared or unwritten tiles keep their values unless the auto-clear reruns.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=32 -> busy high 32 cycles after rst_n rises; afterwards every address reads M=0x00.
- ADDR=1, R=0x02, wAR, then wM; ADDR=2, R=0x0a, wAR, then wM -> M=0x02 after the first write, M=0x0a after the second; reloading AR=1 gives M=0x02 one cycle later.
- AR=1 (M=0x02), srcA=1, wAR -> AR=2, next cycle M=0x0a (indirect).
- mem[3]=0xFF, bump_inc -> busy for 2 cycles, bump_done pulse, M=0x00; bump_dec on 0x00 -> 0xFF; bump_inc and bump_dec together -> no change, no pulse.
- clr_start, then wAR with ADDR=5 and wM with R=0x33 during busy -> ignored; AR unchanged; mem[5]=0 after the clear.
- rst_n pulsed low during BUMP_WR with CLEAR_ON_RESET=0 -> AR=0, M=0, busy=0 immediately, no bump_done. DEPTH=24: a write at ADDR=30 is dropped and M reads 0x00.

Source files
------------

// File: rtl/hrm_memory_ext.sv
// HRM floor-tile memory: synchronous-read RAM behind an address register, with
// internal BUMP+/BUMP- read-modify-write and a clear sequencer.
module hrm_memory_ext #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] R,
    input  logic              srcA,
    input  logic              wAR,
    input  logic              wM,
    input  logic              bump_inc,
    input  logic              bump_dec,
    input  logic              clr_start,
    output logic [DATA_W-1:0] M,
    output logic [ADDR_W-1:0] AR,
    output logic              busy,
    output logic              bump_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_BUMP_RD = 2'd2,
        S_BUMP_WR = 2'd3
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ar, w_ar_nxt;
    logic [DATA_W-1:0] r_m, w_m_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_op, w_op_nxt;
    logic              r_done, w_done_nxt;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_m_clr;
    logic              w_ar_ok;
    logic [DATA_W-1:0] w_rd;

    // Tiles beyond DEPTH read as zero and swallow writes.
    assign w_ar_ok = (32'(r_ar) < DEPTH);
    assign w_rd    = w_ar_ok ? r_mem[r_ar] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ar_nxt    = r_ar;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_done_nxt  = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_ar;
        w_wdata     = R;
        w_m_clr     = 1'b0;
        w_m_nxt     = '0;

        case (r_state)
            S_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end else if (bump_inc ^ bump_dec) begin
                    w_state_nxt = S_BUMP_RD;
                    w_op_nxt    = bump_dec;
                end else begin
                    // Write uses the old AR even when AR reloads on the same edge.
                    w_we = wM && w_ar_ok;
                    if (wAR) begin
                        w_ar_nxt = srcA ? r_m[ADDR_W-1:0] : ADDR;
                    end
                end
            end
            S_CLEAR: begin
                w_we      = 1'b1;
                w_waddr   = r_cnt;
                w_wdata   = '0;
                w_cnt_nxt = r_cnt + ADDR_W'(1);
                if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_m_clr     = 1'b1;
                end
            end
            S_BUMP_RD: begin
                w_state_nxt = S_BUMP_WR;
            end
            S_BUMP_WR: begin
                w_wdata     = r_op ? (r_m - DATA_W'(1)) : (r_m + DATA_W'(1));
                w_we        = w_ar_ok;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_m_clr) begin
            w_m_nxt = '0;
        end else if (w_we && (w_waddr == r_ar)) begin
            w_m_nxt = w_wdata;
        end else begin
            w_m_nxt = w_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ar   <= '0;
            r_m    <= '0;
            r_cnt  <= '0;
            r_op   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ar   <= w_ar_nxt;
            r_m    <= w_m_nxt;
            r_cnt  <= w_cnt_nxt;
            r_op   <= w_op_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Tile storage has no reset; only the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign M         = r_m;
    assign AR        = r_ar;
    assign busy      = (r_state != S_IDLE);
    assign bump_done = r_done;

endmodule

// File: tb/tb_hrm_memory_ext.sv
// Directed bench for hrm_memory_ext: one instance with auto-clear (DEPTH=32),
// one without auto-clear and a short tile range (DEPTH=24).
module tb_hrm_memory_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: auto-clear, full depth
    logic       a_rst_n, a_srcA, a_wAR, a_wM, a_inc, a_dec, a_clr;
    logic [4:0] a_ADDR, a_AR;
    logic [7:0] a_R, a_M;
    logic       a_busy, a_done;

    // Instance B: no auto-clear, DEPTH=24
    logic       b_rst_n, b_srcA, b_wAR, b_wM, b_inc, b_dec, b_clr;
    logic [4:0] b_ADDR, b_AR;
    logic [7:0] b_R, b_M;
    logic       b_busy, b_done;

    hrm_memory_ext #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .ADDR(a_ADDR), .R(a_R), .srcA(a_srcA),
        .wAR(a_wAR), .wM(a_wM), .bump_inc(a_inc), .bump_dec(a_dec),
        .clr_start(a_clr), .M(a_M), .AR(a_AR), .busy(a_busy), .bump_done(a_done)
    );

    hrm_memory_ext #(.DATA_W(8), .ADDR_W(5), .DEPTH(24), .CLEAR_ON_RESET(0)) u_b (
        .clk(clk), .rst_n(b_rst_n), .ADDR(b_ADDR), .R(b_R), .srcA(b_srcA),
        .wAR(b_wAR), .wM(b_wM), .bump_inc(b_inc), .bump_dec(b_dec),
        .clr_start(b_clr), .M(b_M), .AR(b_AR), .busy(b_busy), .bump_done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;
    int bad;

    initial begin
        a_rst_n = 1'b0; a_srcA = 1'b0; a_wAR = 1'b0; a_wM = 1'b0;
        a_inc = 1'b0; a_dec = 1'b0; a_clr = 1'b0; a_ADDR = '0; a_R = '0;
        b_rst_n = 1'b0; b_srcA = 1'b0; b_wAR = 1'b0; b_wM = 1'b0;
        b_inc = 1'b0; b_dec = 1'b0; b_clr = 1'b0; b_ADDR = '0; b_R = '0;
        tick();
        tick();

        // Reset values; A is busy in reset because it enters CLEAR
        chk("a_rst_busy", 32'(a_busy), 32'd1);
        chk("a_rst_ar",   32'(a_AR),   32'd0);
        chk("a_rst_m",    32'(a_M),    32'd0);
        chk("a_rst_done", 32'(a_done), 32'd0);
        chk("b_rst_busy", 32'(b_busy), 32'd0);

        // Auto-clear lasts DEPTH cycles after release
        a_rst_n = 1'b1;
        n = 0;
        while (a_busy && n < 200) begin
            tick();
            n++;
        end
        chk("a_autoclr_cycles", 32'(n), 32'd32);

        bad = 0;
        for (int i = 0; i < 32; i++) begin
            a_ADDR = 5'(i); a_wAR = 1'b1;
            tick();
            a_wAR = 1'b0;
            tick();
            if (a_M !== 8'h00) bad++;
        end
        chk("a_all_zero", 32'(bad), 32'd0);

        // Direct writes, write-first M
        a_ADDR = 5'd1; a_R = 8'h02; a_wAR = 1'b1; tick();
        a_wAR = 1'b0; a_wM = 1'b1; tick();
        a_wM = 1'b0;
        chk("a_wr1_m", 32'(a_M), 32'h02);
        a_ADDR = 5'd2; a_R = 8'h0a; a_wAR = 1'b1; tick();
        a_wAR = 1'b0; a_wM = 1'b1; tick();
        a_wM = 1'b0;
        chk("a_wr2_m", 32'(a_M), 32'h0a);
        a_ADDR = 5'd1; a_wAR = 1'b1; tick();
        a_wAR = 1'b0;
        chk("a_reload_ar", 32'(a_AR), 32'd1);
        tick();
        chk("a_reload_m", 32'(a_M), 32'h02);

        // Indirect: AR <= M[4:0] = 2
        a_srcA = 1'b1; a_wAR = 1'b1; tick();
        a_srcA = 1'b0; a_wAR = 1'b0;
        chk("a_ind_ar", 32'(a_AR), 32'd2);
        tick();
        chk("a_ind_m", 32'(a_M), 32'h0a);

        // BUMP+ on 0xFF wraps to 0x00
        a_ADDR = 5'd3; a_R = 8'hFF; a_wAR = 1'b1; tick();
        a_wAR = 1'b0; a_wM = 1'b1; tick();
        a_wM = 1'b0;
        chk("a_wr3_m", 32'(a_M), 32'hFF);
        a_inc = 1'b1; tick();
        a_inc = 1'b0;
        chk("a_binc_busy1", 32'(a_busy), 32'd1);
        tick();
        chk("a_binc_busy2", 32'(a_busy), 32'd1);
        chk("a_binc_nodone", 32'(a_done), 32'd0);
        tick();
        chk("a_binc_idle", 32'(a_busy), 32'd0);
        chk("a_binc_done", 32'(a_done), 32'd1);
        chk("a_binc_m", 32'(a_M), 32'h00);
        tick();
        chk("a_binc_pulse", 32'(a_done), 32'd0);
        chk("a_binc_mem", 32'(a_M), 32'h00);

        // BUMP- on 0x00 wraps to 0xFF
        a_dec = 1'b1; tick();
        a_dec = 1'b0; tick(); tick();
        chk("a_bdec_done", 32'(a_done), 32'd1);
        chk("a_bdec_m", 32'(a_M), 32'hFF);

        // Both bump inputs: ignored
        tick();
        a_inc = 1'b1; a_dec = 1'b1; tick();
        a_inc = 1'b0; a_dec = 1'b0;
        chk("a_both_busy", 32'(a_busy), 32'd0);
        tick(); tick();
        chk("a_both_done", 32'(a_done), 32'd0);
        chk("a_both_m", 32'(a_M), 32'hFF);

        // Clear with commands attempted during busy
        a_clr = 1'b1; tick();
        a_clr = 1'b0; a_ADDR = 5'd5; a_R = 8'h33; a_wAR = 1'b1; a_wM = 1'b1;
        n = 0;
        while (a_busy && n < 200) begin
            n++;
            tick();
        end
        a_wAR = 1'b0; a_wM = 1'b0;
        chk("a_clr_cycles", 32'(n), 32'd32);
        chk("a_clr_ar", 32'(a_AR), 32'd3);
        chk("a_clr_m", 32'(a_M), 32'h00);
        a_ADDR = 5'd5; a_wAR = 1'b1; tick();
        a_wAR = 1'b0; tick();
        chk("a_clr_mem5", 32'(a_M), 32'h00);

        // Instance B: no auto-clear, reset aborts a bump
        b_rst_n = 1'b1;
        tick();
        chk("b_idle_busy", 32'(b_busy), 32'd0);
        b_ADDR = 5'd4; b_R = 8'h44; b_wAR = 1'b1; tick();
        b_wAR = 1'b0; b_wM = 1'b1; tick();
        b_wM = 1'b0;
        chk("b_wr4_m", 32'(b_M), 32'h44);
        b_inc = 1'b1; tick();
        b_inc = 1'b0; tick();
        chk("b_bwr_busy", 32'(b_busy), 32'd1);
        b_rst_n = 1'b0;
        #1;
        chk("b_abort_ar", 32'(b_AR), 32'd0);
        chk("b_abort_m", 32'(b_M), 32'h00);
        chk("b_abort_busy", 32'(b_busy), 32'd0);
        chk("b_abort_done", 32'(b_done), 32'd0);
        tick();
        b_rst_n = 1'b1;
        tick();
        chk("b_abort_nodone", 32'(b_done), 32'd0);
        b_ADDR = 5'd4; b_wAR = 1'b1; tick();
        b_wAR = 1'b0; tick();
        chk("b_abort_mem4", 32'(b_M), 32'h44);

        // Out-of-range tile: write dropped, reads zero, bump still pulses
        b_ADDR = 5'd30; b_wAR = 1'b1; tick();
        b_wAR = 1'b0;
        chk("b_oor_ar", 32'(b_AR), 32'd30);
        b_R = 8'h55; b_wM = 1'b1; tick();
        b_wM = 1'b0;
        chk("b_oor_wr_m", 32'(b_M), 32'h00);
        tick();
        chk("b_oor_rd_m", 32'(b_M), 32'h00);
        b_inc = 1'b1; tick();
        b_inc = 1'b0; tick(); tick();
        chk("b_oor_bdone", 32'(b_done), 32'd1);
        chk("b_oor_bm", 32'(b_M), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
